button_conditioner: RTL

- Front-end stage for the slot-machine top level. Sits between the raw board push-buttons (roll, stop) and the roll/stop control logic.
- Per channel: two-flop synchronizer, debounce state machine, one-cycle press/release pulses and a long-press pulse.
- Replaces the raw prev-button edge detectors, so downstream logic sees exactly one clean pulse per physical press.

---
 rtl/button_conditioner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: two-flop sync, debounce FSM and press/release/long pulses per push-button channel
// Ports:
//   clk         - master clock
//   rst         - synchronous active-high reset
//   btn_raw     - raw asynchronous button levels, active-high
//   btn_level   - debounced level, 1 = pressed
//   btn_press   - one-cycle pulse on accepted press (and auto-repeat)
//   btn_release - one-cycle pulse on accepted release
//   btn_long    - one-cycle pulse after HOLD_CYCLES held in PRESSED
// Optional: define BUTTON_CONDITIONER_REPEAT_EN for auto-repeat press pulses after btn_long.
module button_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);
  localparam int MAX_DH = DEBOUNCE_CYCLES > HOLD_CYCLES ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C = MAX_DH > REPEAT_CYCLES ? MAX_DH : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam logic [CW-1:0] RP1 = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [NUM_BTN-1:0] r_s1, r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t          r_state;
    logic [CW-1:0]   r_cnt, r_hold;
    logic            r_level, r_press, r_release, r_long;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
    logic [CW-1:0]   r_rep;
`endif
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_hold    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        r_rep     <= '0;
`endif
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        case (r_state)
          IDLE:
            if (r_s2[g]) begin
              r_state <= PRESS_WAIT;
              r_cnt   <= ONE;
            end
          PRESS_WAIT:
            if (!r_s2[g]) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == DB) begin
              r_state <= PRESSED;
              r_level <= 1'b1;
              r_press <= 1'b1;
              r_hold  <= '0;
              r_cnt   <= '0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
              r_rep   <= '0;
`endif
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          PRESSED: begin
            // hold counter saturates so btn_long fires exactly once per press
            if (r_hold != HD) begin
              r_hold <= r_hold + ONE;
              r_long <= (r_hold == HD - ONE);
            end
            if (!r_s2[g]) begin
              r_state <= RELEASE_WAIT;
              r_cnt   <= ONE;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
              r_rep   <= '0;
`endif
            end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
            else if (r_hold == HD) begin
              r_rep   <= (r_rep == RP1) ? '0 : r_rep + ONE;
              r_press <= (r_rep == RP1);
            end
`endif
          end
          RELEASE_WAIT:
            // hold counter kept on bounce-back so btn_long is not re-issued
            if (r_s2[g]) begin
              r_state <= PRESSED;
              r_cnt   <= '0;
            end else if (r_cnt == DB) begin
              r_state   <= IDLE;
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_cnt     <= '0;
              r_hold    <= '0;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          default: r_state <= IDLE;
        endcase
      end
    end
    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_long[g]    = r_long;
  end
endmodule
